seq_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector. Successor to the fixed 2-bit-state "101" detector.

---
 rtl/seq_detector_param.sv | 126 ++++++++++++
 tb/tb_seq_detector_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//  Parametrised serial bit-pattern detector (Moore, prefix-tracking FSM).
//  The state is the length of the longest pattern prefix that is also a
//  suffix of the accepted bit stream. The full transition table is computed
//  at elaboration from PATTERN, so the runtime logic is a table lookup.
//
//  Parameters
//   PATTERN_LEN  pattern length N (2..16)
//   PATTERN      pattern bits, PATTERN[N-1] is received first
//   OVERLAP      1: matches may share bits, 0: a completed match restarts
//   CNT_W        width of the saturating match counter
//
//  Ports
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   en         sample enable, x is consumed only when en=1
//   clr        synchronous clear of state and counter (priority over en)
//   x          serial data bit
//   y          match flag, high while state == N
//   state      current matched-prefix length 0..N
//   match_cnt  matches since reset/clr, saturating
// ---------------------------------------------------------------------------
module seq_detector_param #(
    parameter int                     PATTERN_LEN = 3,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 3'b101,
    parameter bit                     OVERLAP     = 1'b1,
    parameter int                     CNT_W       = 8,
    localparam int                    SW          = $clog2(PATTERN_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             x,
    output logic             y,
    output logic [SW-1:0]    state,
    output logic [CNT_W-1:0] match_cnt
);

    if (PATTERN_LEN < 2 || PATTERN_LEN > 16 || CNT_W < 1) begin : g_bad_param
        $error("seq_detector_param: PATTERN_LEN must be 2..16 and CNT_W >= 1");
    end

    // Next prefix length after appending bit xb to the prefix of length s.
    // Candidate string is PATTERN[N-1 -: base] followed by xb; the result is
    // the longest suffix of the candidate that equals a pattern prefix.
    // Ascending k with "last hit wins" yields the largest such k.
    function automatic int calc_next(input int s, input bit xb);
        int base;
        int kmax;
        int res;
        int j;
        bit ok;
        bit cb;
        base = (!OVERLAP && s == PATTERN_LEN) ? 0 : s;
        kmax = (base + 1 < PATTERN_LEN) ? base + 1 : PATTERN_LEN;
        res  = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k <= kmax) begin
                ok = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    if (i < k) begin
                        j  = base + 1 - k + i;   // position in the candidate
                        cb = (j == base) ? xb : PATTERN[PATTERN_LEN-1-j];
                        if (cb != PATTERN[PATTERN_LEN-1-i]) ok = 1'b0;
                    end
                end
                if (ok) res = k;
            end
        end
        return res;
    endfunction

    // Transition table, indexed [state][x], fixed at elaboration.
    logic [PATTERN_LEN:0][1:0][SW-1:0] nxt_tbl;

    for (genvar s = 0; s <= PATTERN_LEN; s++) begin : g_st
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int NXT = calc_next(s, (b == 1));
            assign nxt_tbl[s][b] = SW'(NXT);
        end
    end

    logic [SW-1:0]    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    nxt_state;

    // Encodings above N are unreachable; they fall back to state 0.
    always_comb begin
        nxt_state = '0;
        for (int s = 0; s <= PATTERN_LEN; s++) begin
            if (state_q == SW'(s)) nxt_state = nxt_tbl[s][x];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = '0;
            cnt_d   = '0;
        end else if (en) begin
            state_d = nxt_state;
            // Count on the edge that completes a match; hold at all-ones.
            if (nxt_state == SW'(PATTERN_LEN) && cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state     = state_q;
    assign match_cnt = cnt_q;
    assign y         = (state_q == SW'(PATTERN_LEN));

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
//  Four detector instances share one input stream: defaults (101, overlap),
//  non-overlapping 101, 4-bit 1101 and a 2-bit counter variant. Stimulus
//  pushes hand-computed expectations tagged with the cycle they become
//  visible; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic reset, en, clr, x;

    logic       y_def, y_nov, y_n4, y_c2;
    logic [1:0] st_def, st_nov, st_c2;
    logic [2:0] st_n4;
    logic [7:0] cnt_def, cnt_nov, cnt_n4;
    logic [1:0] cnt_c2;

    always #5 clk = ~clk;

    seq_detector_param u_def (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .x(x),
        .y(y_def), .state(st_def), .match_cnt(cnt_def));

    seq_detector_param #(.OVERLAP(1'b0)) u_nov (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .x(x),
        .y(y_nov), .state(st_nov), .match_cnt(cnt_nov));

    seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1101)) u_n4 (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .x(x),
        .y(y_n4), .state(st_n4), .match_cnt(cnt_n4));

    seq_detector_param #(.CNT_W(2)) u_c2 (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .x(x),
        .y(y_c2), .state(st_c2), .match_cnt(cnt_c2));

    localparam int D_DEF = 0, D_NOV = 1, D_N4 = 2, D_C2 = 3;

    typedef struct {
        int    chk_cyc;
        int    dut;
        int    st;
        int    y;
        int    cnt;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void get_out(input int d, output int st, output int yy, output int cn);
        case (d)
            D_DEF:   begin st = int'(st_def); yy = int'(y_def); cn = int'(cnt_def); end
            D_NOV:   begin st = int'(st_nov); yy = int'(y_nov); cn = int'(cnt_nov); end
            D_N4:    begin st = int'(st_n4);  yy = int'(y_n4);  cn = int'(cnt_n4);  end
            default: begin st = int'(st_c2);  yy = int'(y_c2);  cn = int'(cnt_c2);  end
        endcase
    endfunction

    task automatic chk_now(input string nm, input int d, input int st, input int yy, input int cn);
        int a_st, a_y, a_cn;
        get_out(d, a_st, a_y, a_cn);
        chk({nm, " state"}, a_st, st);
        chk({nm, " y"}, a_y, yy);
        chk({nm, " match_cnt"}, a_cn, cn);
    endtask

    // Expectation becomes visible after the next rising edge.
    task automatic push(input string nm, input int d, input int st, input int yy, input int cn);
        exp_t e;
        e.chk_cyc = cyc + 1;
        e.dut = d; e.st = st; e.y = yy; e.cnt = cn; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic step(input logic e, input logic c, input logic xb);
        @(negedge clk);
        en = e; clr = c; x = xb;
    endtask

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge clk) begin
        exp_t it;
        while (sb.size() > 0 && sb[0].chk_cyc <= cyc) begin
            it = sb.pop_front();
            if (it.chk_cyc < cyc) chk({it.nm, " late"}, cyc, it.chk_cyc);
            chk_now(it.nm, it.dut, it.st, it.y, it.cnt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int xs[11]      = '{1,0,1,0,1,0,1,0,1,0,1};
        int def_st[11]  = '{1,2,3,2,3,2,3,2,3,2,3};
        int def_cnt[11] = '{0,0,1,1,2,2,3,3,4,4,5};
        int nov_st[11]  = '{1,2,3,0,1,2,3,0,1,2,3};
        int nov_cnt[11] = '{0,0,1,1,1,1,2,2,2,2,3};
        int c2_cnt[11]  = '{0,0,1,1,2,2,3,3,3,3,3};
        int x4[7]       = '{1,1,0,1,1,0,1};
        int n4_st[7]    = '{1,2,3,4,2,3,4};
        int n4_cnt[7]   = '{0,0,0,1,1,1,2};
        int guard;

        reset = 1'b1; en = 1'b0; clr = 1'b0; x = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk_now("reset def", D_DEF, 0, 0, 0);
        chk_now("reset nov", D_NOV, 0, 0, 0);
        chk_now("reset n4",  D_N4,  0, 0, 0);
        chk_now("reset c2",  D_C2,  0, 0, 0);
        @(negedge clk) reset = 1'b1;

        // Alternating 1010... : overlap, non-overlap and saturation.
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 1'b0, xs[i][0]);
            push("stream def", D_DEF, def_st[i], int'(def_st[i] == 3), def_cnt[i]);
            push("stream nov", D_NOV, nov_st[i], int'(nov_st[i] == 3), nov_cnt[i]);
            push("stream c2",  D_C2,  def_st[i], int'(def_st[i] == 3), c2_cnt[i]);
        end

        // clr wins over en with x=1.
        step(1'b1, 1'b1, 1'b1);
        push("clr def", D_DEF, 0, 0, 0);
        push("clr nov", D_NOV, 0, 0, 0);
        push("clr n4",  D_N4,  0, 0, 0);
        push("clr c2",  D_C2,  0, 0, 0);

        // 1101 with overlap.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, x4[i][0]);
            push("p1101 n4", D_N4, n4_st[i], int'(n4_st[i] == 4), n4_cnt[i]);
        end
        step(1'b1, 1'b1, 1'b0);
        push("clr2 def", D_DEF, 0, 0, 0);
        push("clr2 n4",  D_N4,  0, 0, 0);

        // Enable gating: prefix 10, hold 5 cycles with x toggling, then 1.
        step(1'b1, 1'b0, 1'b1);
        push("en def", D_DEF, 1, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        push("en def", D_DEF, 2, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, (i % 2 == 0));
            push("hold def", D_DEF, 2, 0, 0);
        end
        step(1'b1, 1'b0, 1'b1);
        push("resume def", D_DEF, 3, 1, 1);
        step(1'b0, 1'b0, 1'b0);
        push("yhold def", D_DEF, 3, 1, 1);
        push("yhold c2",  D_C2,  3, 1, 1);
        @(negedge clk);

        // Asynchronous reset mid-cycle while state==3.
        #3 reset = 1'b0;
        en = 1'b1; x = 1'b1;
        #1;
        chk_now("async rst def", D_DEF, 0, 0, 0);
        chk_now("async rst c2",  D_C2,  0, 0, 0);
        @(posedge clk);
        #1;
        chk_now("rst held def", D_DEF, 0, 0, 0);
        @(negedge clk) reset = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        push("post rst def", D_DEF, 1, 0, 0);

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        chk("scoreboard drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
